// File: rtl/bus_pkg.sv
// Shared bus constants and types for the data-bus receive path.
package bus_pkg;
    localparam int BUS_W    = 16;
    localparam int SEL_W    = 2;
    localparam int NUM_DEST = 4;

    typedef logic [BUS_W-1:0] bus_word_t;
    typedef logic [SEL_W-1:0] dest_sel_t;
endpackage

// File: rtl/bus_dest_slot.sv
// One destination slot: data register plus valid flag, popped by ack.
module bus_dest_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             vld,
    output logic             free
);
    logic [WIDTH-1:0] q_d;
    logic             vld_d;

    // An ack on the same edge frees the slot for refill.
    assign free = ~vld | ack;

    always_comb begin
        q_d   = q;
        vld_d = vld;
        if (wr_en) begin
            q_d   = wr_data;
            vld_d = 1'b1;
        end else if (ack) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else begin
            q   <= q_d;
            vld <= vld_d;
        end
    end
endmodule

// File: rtl/bus_demultiplexer_reg.sv
// Steers bus words into four registered slots with ready/valid backpressure
// and a saturating stall counter.
module bus_demultiplexer_reg
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_W,
    parameter int CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [WIDTH-1:0]   DBUS,
    input  logic [SEL_W-1:0]   DSEL,
    input  logic               DVALID,
    output logic               DREADY,
    input  logic               BCAST,
    output logic [WIDTH-1:0]   Q0,
    output logic [WIDTH-1:0]   Q1,
    output logic [WIDTH-1:0]   Q2,
    output logic [WIDTH-1:0]   Q3,
    output logic [NUM_DEST-1:0] Q_VLD,
    input  logic [NUM_DEST-1:0] Q_ACK,
    output logic [CNT_W-1:0]   STALL_CNT
);
    logic [WIDTH-1:0]    slot_q [NUM_DEST];
    logic [NUM_DEST-1:0] slot_free;
    logic [NUM_DEST-1:0] slot_wr;
    logic                xfer;
    logic [CNT_W-1:0]    stall_cnt_d;

    // Ready never looks at DVALID, so the driver sees no comb loop.
    assign DREADY = BCAST ? (&slot_free) : slot_free[DSEL];
    assign xfer   = DVALID & DREADY;

    for (genvar n = 0; n < NUM_DEST; n++) begin : g_slot
        assign slot_wr[n] = xfer & (BCAST | (DSEL == SEL_W'(n)));

        bus_dest_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (CLK),
            .rst_n   (RST_N),
            .wr_en   (slot_wr[n]),
            .wr_data (DBUS),
            .ack     (Q_ACK[n]),
            .q       (slot_q[n]),
            .vld     (Q_VLD[n]),
            .free    (slot_free[n])
        );
    end

    assign Q0 = slot_q[0];
    assign Q1 = slot_q[1];
    assign Q2 = slot_q[2];
    assign Q3 = slot_q[3];

    always_comb begin
        stall_cnt_d = STALL_CNT;
        if (DVALID && !DREADY && (STALL_CNT != {CNT_W{1'b1}})) begin
            stall_cnt_d = STALL_CNT + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STALL_CNT <= '0;
        end else begin
            STALL_CNT <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_demultiplexer_reg.sv
// Directed self-checking bench for bus_demultiplexer_reg (default and CNT_W=2).
module tb_bus_demultiplexer_reg;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] DBUS;
    logic [1:0]  DSEL;
    logic        DVALID, BCAST, DREADY;
    logic [15:0] Q0, Q1, Q2, Q3;
    logic [3:0]  Q_VLD, Q_ACK;
    logic [7:0]  STALL_CNT;

    logic [15:0] s_dbus;
    logic [1:0]  s_dsel;
    logic        s_dvalid, s_bcast, s_dready;
    logic [15:0] s_q0, s_q1, s_q2, s_q3;
    logic [3:0]  s_qvld, s_ack;
    logic [1:0]  s_stall;

    int passes = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    bus_demultiplexer_reg dut (
        .CLK (CLK), .RST_N (RST_N), .DBUS (DBUS), .DSEL (DSEL), .DVALID (DVALID),
        .DREADY (DREADY), .BCAST (BCAST), .Q0 (Q0), .Q1 (Q1), .Q2 (Q2), .Q3 (Q3),
        .Q_VLD (Q_VLD), .Q_ACK (Q_ACK), .STALL_CNT (STALL_CNT)
    );

    bus_demultiplexer_reg #(.WIDTH (16), .CNT_W (2)) dut_sat (
        .CLK (CLK), .RST_N (RST_N), .DBUS (s_dbus), .DSEL (s_dsel), .DVALID (s_dvalid),
        .DREADY (s_dready), .BCAST (s_bcast), .Q0 (s_q0), .Q1 (s_q1), .Q2 (s_q2),
        .Q3 (s_q3), .Q_VLD (s_qvld), .Q_ACK (s_ack), .STALL_CNT (s_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; DBUS = '0; DSEL = '0; DVALID = 1'b0; BCAST = 1'b0; Q_ACK = '0;
        s_dbus = '0; s_dsel = '0; s_dvalid = 1'b0; s_bcast = 1'b0; s_ack = '0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Preload all slots, stall once, then reset asynchronously mid-stream
        DVALID = 1'b1; BCAST = 1'b1; DBUS = 16'h5a5a;
        tick();
        chk("preload_vld", 32'(Q_VLD), 32'hf);
        BCAST = 1'b0; DSEL = 2'd0;
        #1 chk("preload_stall_rdy", 32'(DREADY), 32'h0);
        tick();
        chk("preload_stall_cnt", 32'(STALL_CNT), 32'h1);
        RST_N = 1'b0;
        #1;
        chk("rst_q0", 32'(Q0), 32'h0);
        chk("rst_q3", 32'(Q3), 32'h0);
        chk("rst_vld", 32'(Q_VLD), 32'h0);
        chk("rst_stall", 32'(STALL_CNT), 32'h0);
        chk("rst_dready", 32'(DREADY), 32'h1);
        DVALID = 1'b0;
        tick();
        RST_N = 1'b1;

        // Unicast to slot 2 then slot 0
        DVALID = 1'b1; DSEL = 2'd2; DBUS = 16'h66cd;
        tick();
        chk("uni_q2", 32'(Q2), 32'h66cd);
        DSEL = 2'd0; DBUS = 16'h1234;
        tick();
        DVALID = 1'b0;
        chk("uni_q0", 32'(Q0), 32'h1234);
        chk("uni_vld", 32'(Q_VLD), 32'h5);
        chk("uni_q1", 32'(Q1), 32'h0);
        chk("uni_q3", 32'(Q3), 32'h0);

        // Backpressure on occupied slot 1, released by ack
        DVALID = 1'b1; DSEL = 2'd1; DBUS = 16'hcccc;
        tick();
        chk("bp_load", 32'(Q1), 32'hcccc);
        DBUS = 16'h9999;
        #1 chk("bp_rdy_low", 32'(DREADY), 32'h0);
        repeat (3) tick();
        chk("bp_hold", 32'(Q1), 32'hcccc);
        chk("bp_stall", 32'(STALL_CNT), 32'h3);
        Q_ACK = 4'b0010;
        #1 chk("bp_rdy_ack", 32'(DREADY), 32'h1);
        tick();
        Q_ACK = '0; DVALID = 1'b0;
        chk("bp_q1", 32'(Q1), 32'h9999);
        chk("bp_vld", 32'(Q_VLD), 32'h7);
        chk("bp_stall_hold", 32'(STALL_CNT), 32'h3);

        // Pop and refill slot 3 on the same edge
        DVALID = 1'b1; DSEL = 2'd3; DBUS = 16'h3344;
        tick();
        chk("pr_load", 32'(Q3), 32'h3344);
        Q_ACK = 4'b1000; DBUS = 16'hdddd;
        #1 chk("pr_rdy", 32'(DREADY), 32'h1);
        tick();
        Q_ACK = '0; DVALID = 1'b0;
        chk("pr_q3", 32'(Q3), 32'hdddd);
        chk("pr_vld", 32'(Q_VLD), 32'hf);

        // Broadcast blocked by slot 1, then released by its ack
        Q_ACK = 4'b1101;
        tick();
        Q_ACK = '0;
        chk("bc_pre_vld", 32'(Q_VLD), 32'h2);
        chk("bc_stale_q0", 32'(Q0), 32'h1234);
        DVALID = 1'b1; BCAST = 1'b1; DBUS = 16'habcd;
        #1 chk("bc_rdy_low", 32'(DREADY), 32'h0);
        Q_ACK = 4'b0010;
        #1 chk("bc_rdy", 32'(DREADY), 32'h1);
        tick();
        Q_ACK = '0; DVALID = 1'b0; BCAST = 1'b0;
        chk("bc_q0", 32'(Q0), 32'habcd);
        chk("bc_q2", 32'(Q2), 32'habcd);
        chk("bc_q3", 32'(Q3), 32'habcd);
        chk("bc_vld", 32'(Q_VLD), 32'hf);

        // Ack retains data but clears valid
        Q_ACK = 4'b0001;
        tick();
        Q_ACK = '0;
        chk("ack_q0_kept", 32'(Q0), 32'habcd);
        chk("ack_vld", 32'(Q_VLD), 32'he);

        // Saturation with CNT_W=2
        s_dvalid = 1'b1; s_dsel = 2'd1; s_dbus = 16'h1111;
        tick();
        chk("sat_load", 32'(s_q1), 32'h1111);
        s_dbus = 16'h2222;
        repeat (2) tick();
        chk("sat_cnt2", 32'(s_stall), 32'h2);
        repeat (3) tick();
        chk("sat_cnt5", 32'(s_stall), 32'h3);
        repeat (2) tick();
        chk("sat_hold", 32'(s_stall), 32'h3);
        s_dvalid = 1'b0; s_ack = 4'b0001;
        tick();
        s_ack = '0;
        chk("stray_vld", 32'(s_qvld), 32'h2);
        chk("stray_q0", 32'(s_q0), 32'h0);
        chk("stray_q1", 32'(s_q1), 32'h1111);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/bus_demultiplexer_reg.md
Name: bus_demultiplexer_reg

Overview:
- Receiving end of the 16-bit data bus: takes one word from DBUS and steers it into one of four registered destination slots Q0..Q3, selected by DSEL.
- Each slot holds its word and a valid flag until the downstream consumer acknowledges it.
- DVALID/DREADY handshake with the bus driver provides backpressure when the targeted slot is still occupied.
- Saturating stall counter for bus-contention debug.

Parameters:
- WIDTH, 16, data bus and slot width in bits
- CNT_W, 8, width of the stall counter

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- DBUS  input  WIDTH  incoming bus word
- DSEL  input  2  destination slot index (0..3)
- DVALID  input  1  bus driver presents a valid word
- DREADY  output  1  targeted slot can accept this cycle
- BCAST  input  1  when high with DVALID, write the word to all four slots
- Q0, Q1, Q2, Q3  output  WIDTH  slot data registers
- Q_VLD  output  4  per-slot valid flags (bit n = slot n)
- Q_ACK  input  4  consumer pops slot n; clears Q_VLD[n]
- STALL_CNT  output  CNT_W  cycles with DVALID=1 and DREADY=0, saturating

Behaviour:
- Reset (RST_N=0, asynchronous assert, synchronous release):
  - Q0..Q3 = 0, Q_VLD = 4'b0000, STALL_CNT = 0.
  - DREADY = 1 while in reset.
- Slot n is free when Q_VLD[n]=0 or Q_ACK[n]=1 in the same cycle (pop-and-refill allowed).
- DREADY is combinational:
  - BCAST=0: DREADY = free(DSEL).
  - BCAST=1: DREADY = all four slots free.
  - DREADY may depend on DVALID-independent inputs only; no combinational path from DVALID to DREADY.
- Transfer occurs on a rising CLK when DVALID=1 and DREADY=1. Latency is 1 cycle:
  - Unicast (BCAST=0): Q[DSEL] <= DBUS; Q_VLD[DSEL] <= 1.
  - Broadcast (BCAST=1): all Q <= DBUS; Q_VLD <= 4'b1111.
- Q_ACK[n] with Q_VLD[n]=1 and no write to slot n the same edge: Q_VLD[n] <= 0. Qn data is retained; stale data stays visible but is invalid.
- Q_ACK[n] with Q_VLD[n]=0 is ignored; no error.
- Simultaneous Q_ACK[n] and write to slot n: the write wins, so Q_VLD[n] stays 1 and Qn takes the new word.
- Acks on other slots are independent of the write in progress.
- No transfer when DVALID=0. DBUS/DSEL/BCAST are don't-care then.
- Stall: DVALID=1 and DREADY=0 at a clock edge increments STALL_CNT, saturating at 2^CNT_W-1. It is never cleared except by reset.
- Driver-side rule: once DVALID is high and DREADY low, the driver must hold DBUS/DSEL/BCAST stable until transfer. This block does not check the rule.
- Reset mid-operation: all slots are invalidated immediately; any pending word on the bus is lost.

Decomposition:
- Shared package bus_pkg:
  - BUS_W = 16
  - SEL_W = 2
  - NUM_DEST = 4
  - typedef bus_word_t (logic [BUS_W-1:0])
  - typedef dest_sel_t (logic [SEL_W-1:0])
- Sub-module bus_dest_slot: one WIDTH register plus valid flag.
  - Inputs: wr_en, wr_data, ack.
  - Outputs: q, vld, free.
  - Instantiated NUM_DEST times.
- The top level holds the DSEL decode, DREADY/BCAST logic and the stall counter.

Test Plan:
- Reset with RST_N=0 mid-stream, slots preloaded → Q0..Q3=0000, Q_VLD=0000, STALL_CNT=0 and DREADY=1, all without a clock edge.
- Unicast: DVALID=1, DSEL=2, DBUS=66cd, then DSEL=0, DBUS=1234 → next cycle Q2=66cd, then Q0=1234; Q_VLD=0101; Q1/Q3 unchanged at 0000.
- Backpressure: slot 1 holds cccc (valid), then drive DSEL=1, DBUS=9999 for 3 cycles with no ack → DREADY=0, Q1 stays cccc, STALL_CNT=3. Assert Q_ACK[1] in cycle 4 → transfer that edge, Q1=9999, Q_VLD[1]=1.
- Pop and refill the same edge: Q_VLD[3]=1 with Q3=3344, then Q_ACK[3]=1 together with DVALID=1, DSEL=3, DBUS=dddd → DREADY=1, Q3=dddd, Q_VLD[3] stays 1.
- Broadcast: BCAST=1, DBUS=abcd, Q_VLD=0010 → DREADY=0. Ack slot 1 → transfer, Q0..Q3=abcd, Q_VLD=1111.
- Saturation (CNT_W=2 override): 5 stall cycles → STALL_CNT = 3, then holds at 3. Stray Q_ACK[0] while Q_VLD[0]=0 → no change.
